ocw3_read_poll_control: RTL and testbench

//  Clocked, parametrised OCW3 decoder for the 8259A control logic. Holds special-mask-mode and

---
 rtl/ocw3_read_poll_control_if.sv | 29 ++
 rtl/ocw3_read_poll_control.sv | 127 ++++++++++++
 tb/tb_ocw3_read_poll_control.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocw3_read_poll_control_if.sv
// +--------------------------------------------------------------------------+
// | ocw3_read_poll_control_if : CPU write/read strobes and read-data return   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ocw3_read_poll_control_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  write_icw1;
  logic                  write_ocw3;
  logic [DATA_WIDTH-1:0] internal_data_bus;
  logic                  read_strobe;
  logic                  read_address_a0;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_data_valid;

  modport master (
    output write_icw1, write_ocw3, internal_data_bus, read_strobe, read_address_a0,
    input  read_data, read_data_valid
  );

  modport slave (
    input  write_icw1, write_ocw3, internal_data_bus, read_strobe, read_address_a0,
    output read_data, read_data_valid
  );
endinterface

`default_nettype wire

// File: rtl/ocw3_read_poll_control.sv
// +--------------------------------------------------------------------------+
// | ocw3_read_poll_control : OCW3 decode, poll command and CPU read-data mux |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module ocw3_read_poll_control #(
  parameter int NUM_IRQ      = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int LEVEL_WIDTH  = 3,
  parameter int RR_HOLD_MODE = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  ocw3_read_poll_control_if.slave bus,
  input  logic [NUM_IRQ-1:0]     irr,
  input  logic [NUM_IRQ-1:0]     isr,
  input  logic [NUM_IRQ-1:0]     imr,
  input  logic                   interrupt_pending,
  input  logic [LEVEL_WIDTH-1:0] highest_level,
  output logic                   special_mask_mode,
  output logic                   enable_read_register,
  output logic                   read_register_isr_or_irr,
  output logic                   poll_armed,
  output logic                   poll_ack
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } poll_state_t;

  poll_state_t           state;
  poll_state_t           next_state;
  logic                  read_accept;
  logic [DATA_WIDTH-1:0] poll_word;
  logic [DATA_WIDTH-1:0] read_view;
  logic                  unused_bus_bits;

  wire ocw3_esmm = bus.internal_data_bus[6];
  wire ocw3_smm  = bus.internal_data_bus[5];
  wire ocw3_poll = bus.internal_data_bus[2];
  wire ocw3_rr   = bus.internal_data_bus[1];
  wire ocw3_ris  = bus.internal_data_bus[0];

  assign unused_bus_bits = ^{bus.internal_data_bus[DATA_WIDTH-1:7], bus.internal_data_bus[4:3]};

  // A write in the same cycle as a read always wins; the read is discarded.
  assign read_accept = bus.read_strobe & ~bus.write_ocw3 & ~bus.write_icw1;
  assign poll_armed  = (state == ARMED);

  always_comb begin
    next_state = state;
    if (bus.write_icw1) begin
      next_state = IDLE;
    end else if (bus.write_ocw3) begin
      next_state = ocw3_poll ? ARMED : IDLE;
    end else if (bus.read_strobe) begin
      next_state = IDLE;
    end
  end

  always_comb begin
    poll_word                 = '0;
    poll_word[DATA_WIDTH-1]   = interrupt_pending;
    if (interrupt_pending) begin
      poll_word[LEVEL_WIDTH-1:0] = highest_level;
    end

    read_view = '0;
    if (state == ARMED) begin
      read_view = poll_word;
    end else if (bus.read_address_a0) begin
      read_view = DATA_WIDTH'(imr);
    end else if (enable_read_register) begin
      read_view = read_register_isr_or_irr ? DATA_WIDTH'(isr) : DATA_WIDTH'(irr);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      special_mask_mode        <= 1'b0;
      enable_read_register     <= 1'b1;
      read_register_isr_or_irr <= 1'b0;
      poll_ack                 <= 1'b0;
      bus.read_data            <= '0;
      bus.read_data_valid      <= 1'b0;
    end else if (bus.write_icw1) begin
      special_mask_mode        <= 1'b0;
      enable_read_register     <= 1'b1;
      read_register_isr_or_irr <= 1'b0;
      poll_ack                 <= 1'b0;
      bus.read_data_valid      <= 1'b0;
    end else begin
      poll_ack            <= read_accept & (state == ARMED) & interrupt_pending;
      bus.read_data_valid <= read_accept;
      if (read_accept) begin
        bus.read_data <= read_view;
      end
      if (bus.write_ocw3) begin
        if (ocw3_esmm) begin
          special_mask_mode <= ocw3_smm;
        end
        if (RR_HOLD_MODE != 0) begin
          if (ocw3_rr) begin
            enable_read_register     <= 1'b1;
            read_register_isr_or_irr <= ocw3_ris;
          end
        end else begin
          enable_read_register     <= ocw3_rr;
          read_register_isr_or_irr <= ocw3_ris;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ocw3_read_poll_control.sv
// +--------------------------------------------------------------------------+
// | tb_ocw3_read_poll_control : scoreboard bench for the OCW3/poll/read block |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ocw3_read_poll_control;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic [7:0] irr, isr, imr;
  logic       interrupt_pending;
  logic [2:0] highest_level;
  logic       special_mask_mode, enable_read_register, read_register_isr_or_irr;
  logic       poll_armed, poll_ack;

  int         checks;
  int         errors;
  exp_t       sb[$];
  logic [7:0] model_rd;

  ocw3_read_poll_control_if #(.DATA_WIDTH(8)) bus ();

  ocw3_read_poll_control #(
    .NUM_IRQ(8), .DATA_WIDTH(8), .LEVEL_WIDTH(3), .RR_HOLD_MODE(1)
  ) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .bus                      (bus),
    .irr                      (irr),
    .isr                      (isr),
    .imr                      (imr),
    .interrupt_pending        (interrupt_pending),
    .highest_level            (highest_level),
    .special_mask_mode        (special_mask_mode),
    .enable_read_register     (enable_read_register),
    .read_register_isr_or_irr (read_register_isr_or_irr),
    .poll_armed               (poll_armed),
    .poll_ack                 (poll_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard side: every valid pulse must match the oldest pushed expectation.
  always @(negedge clock) begin
    if (bus.read_data_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got read_data=%h with no read outstanding", bus.read_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.read_data !== e.data || poll_ack !== e.ack) begin
          errors++;
          $display("FAIL read_result: got data=%h ack=%b, expected data=%h ack=%b",
                   bus.read_data, poll_ack, e.data, e.ack);
        end
      end
    end else if (poll_ack !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL stray_poll_ack: got poll_ack=%b without read_data_valid, expected 0", poll_ack);
    end
  end

  task automatic drive_cycle(input logic icw1, input logic ocw3, input logic [7:0] data,
                             input logic strobe, input logic a0);
    @(negedge clock);
    bus.write_icw1        = icw1;
    bus.write_ocw3        = ocw3;
    bus.internal_data_bus = data;
    bus.read_strobe       = strobe;
    bus.read_address_a0   = a0;
    @(negedge clock);
    bus.write_icw1        = 1'b0;
    bus.write_ocw3        = 1'b0;
    bus.read_strobe       = 1'b0;
    bus.read_address_a0   = 1'b0;
  endtask

  task automatic do_read(input logic a0, input logic [7:0] exp_data, input logic exp_ack);
    sb.push_back('{data: exp_data, ack: exp_ack});
    model_rd = exp_data;
    drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, a0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    checks++;
    if ({special_mask_mode, enable_read_register, read_register_isr_or_irr, poll_armed,
         poll_ack, bus.read_data, bus.read_data_valid} !== {5'b01000, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got smm=%b rr=%b ris=%b armed=%b ack=%b rd=%h v=%b, expected 0 1 0 0 0 00 0",
               special_mask_mode, enable_read_register, read_register_isr_or_irr, poll_armed,
               poll_ack, bus.read_data, bus.read_data_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_irr_read;
    irr = 8'h25;
    do_read(1'b0, 8'h25, 1'b0);
    imr = 8'hC3;
    do_read(1'b1, 8'hC3, 1'b0);
  endtask

  task automatic test_isr_select;
    drive_cycle(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
    checks++;
    if (enable_read_register !== 1'b1 || read_register_isr_or_irr !== 1'b1) begin
      errors++;
      $display("FAIL ocw3_0b: got rr=%b ris=%b, expected 1 1", enable_read_register, read_register_isr_or_irr);
    end
    isr = 8'h10;
    do_read(1'b0, 8'h10, 1'b0);
  endtask

  task automatic test_rr_hold;
    drive_cycle(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    checks++;
    if (read_register_isr_or_irr !== 1'b1) begin
      errors++;
      $display("FAIL rr_hold: got ris=%b, expected 1", read_register_isr_or_irr);
    end
    do_read(1'b0, 8'h10, 1'b0);
  endtask

  task automatic test_poll_pending;
    drive_cycle(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    checks++;
    if (poll_armed !== 1'b1) begin
      errors++;
      $display("FAIL poll_arm: got poll_armed=%b, expected 1", poll_armed);
    end
    interrupt_pending = 1'b1;
    highest_level     = 3'd3;
    do_read(1'b1, 8'h83, 1'b1);
    checks++;
    if (poll_armed !== 1'b0) begin
      errors++;
      $display("FAIL poll_disarm: got poll_armed=%b, expected 0", poll_armed);
    end
    interrupt_pending = 1'b0;
  endtask

  task automatic test_poll_empty;
    drive_cycle(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    highest_level = 3'd5;
    do_read(1'b0, 8'h00, 1'b0);
    // P=0 while armed cancels; the next read is a normal ISR read
    drive_cycle(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h08, 1'b0, 1'b0);
    checks++;
    if (poll_armed !== 1'b0) begin
      errors++;
      $display("FAIL poll_cancel: got poll_armed=%b, expected 0", poll_armed);
    end
    do_read(1'b0, 8'h10, 1'b0);
  endtask

  task automatic test_smm;
    drive_cycle(1'b0, 1'b1, 8'h68, 1'b0, 1'b0);
    checks++;
    if (special_mask_mode !== 1'b1) begin
      errors++;
      $display("FAIL smm_set: got smm=%b, expected 1", special_mask_mode);
    end
    drive_cycle(1'b0, 1'b1, 8'h28, 1'b0, 1'b0);
    checks++;
    if (special_mask_mode !== 1'b1) begin
      errors++;
      $display("FAIL smm_hold: got smm=%b, expected 1", special_mask_mode);
    end
    drive_cycle(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 8'h6F, 1'b0, 1'b0);
    checks++;
    if ({special_mask_mode, enable_read_register, read_register_isr_or_irr, poll_armed} !== 4'b0100
        || bus.read_data !== model_rd) begin
      errors++;
      $display("FAIL icw1_priority: got smm=%b rr=%b ris=%b armed=%b rd=%h, expected 0 1 0 0 rd=%h",
               special_mask_mode, enable_read_register, read_register_isr_or_irr, poll_armed,
               bus.read_data, model_rd);
    end
  endtask

  task automatic test_collision;
    drive_cycle(1'b0, 1'b1, 8'h0B, 1'b1, 1'b0);
    checks++;
    if (bus.read_data_valid !== 1'b0 || read_register_isr_or_irr !== 1'b1) begin
      errors++;
      $display("FAIL ocw3_read_collision: got valid=%b ris=%b, expected 0 1",
               bus.read_data_valid, read_register_isr_or_irr);
    end
    isr = 8'h44;
    do_read(1'b0, 8'h44, 1'b0);
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    checks++;
    if (bus.read_data_valid !== 1'b0 || read_register_isr_or_irr !== 1'b0 || bus.read_data !== 8'h44) begin
      errors++;
      $display("FAIL icw1_read_collision: got valid=%b ris=%b rd=%h, expected 0 0 44",
               bus.read_data_valid, read_register_isr_or_irr, bus.read_data);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    irr = 8'h11;
    bus.read_strobe     = 1'b1;
    bus.read_address_a0 = 1'b0;
    sb.push_back('{data: 8'h11, ack: 1'b0});
    @(negedge clock);
    irr = 8'h22;
    sb.push_back('{data: 8'h22, ack: 1'b0});
    @(negedge clock);
    imr = 8'h5E;
    bus.read_address_a0 = 1'b1;
    sb.push_back('{data: 8'h5E, ack: 1'b0});
    model_rd = 8'h5E;
    @(negedge clock);
    bus.read_strobe     = 1'b0;
    bus.read_address_a0 = 1'b0;
  endtask

  task automatic test_async_reset_poll;
    drive_cycle(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0);
    interrupt_pending = 1'b1;
    highest_level     = 3'd6;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (poll_armed !== 1'b0 || poll_ack !== 1'b0 || read_register_isr_or_irr !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_poll: got armed=%b ack=%b ris=%b, expected 0 0 0",
               poll_armed, poll_ack, read_register_isr_or_irr);
    end
    @(negedge clock);
    reset_n = 1'b1;
    irr = 8'h5A;
    do_read(1'b0, 8'h5A, 1'b0);
    interrupt_pending = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    model_rd = 8'h00;
    reset_n = 1'b1;
    irr = 8'h00; isr = 8'h00; imr = 8'h00;
    interrupt_pending = 1'b0;
    highest_level = 3'd0;
    bus.write_icw1 = 1'b0;
    bus.write_ocw3 = 1'b0;
    bus.internal_data_bus = 8'h00;
    bus.read_strobe = 1'b0;
    bus.read_address_a0 = 1'b0;

    test_reset;
    test_irr_read;
    test_isr_select;
    test_rr_hold;
    test_poll_pending;
    test_poll_empty;
    test_smm;
    test_collision;
    test_back_to_back;
    test_async_reset_poll;

    repeat (3) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d reads without a valid pulse, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
